bouncing_box_gen: RTL and testbench

- Animated pixel generator fed directly by the VGA sync stage. It consumes pixel_x, pixel_y and video_on.
- It draws a fixed border wall and a square box that bounces inside the wall, moving once per frame.
- It produces a registered 12-bit RGB value for the VGA connector.
- It replaces the static pixel generator in the VGA top level.

---
 rtl/bouncing_box_gen.sv | 166 ++++++++++++++++
 tb/tb_bouncing_box_gen.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bouncing_box_gen.sv
// Bouncing-box pixel generator: fixed wall border plus a square box
// that bounces inside it, stepping once per frame during vertical blank.
module bouncing_box_gen #(
    parameter int          H_MAX      = 640,
    parameter int          V_MAX      = 480,
    parameter int          WALL_W     = 8,
    parameter int          BOX_SIZE   = 32,
    parameter int          BOX_VEL    = 2,
    parameter logic [11:0] BOX_COLOR  = 12'hF00,
    parameter logic [11:0] WALL_COLOR = 12'h00F,
    parameter logic [11:0] BG_COLOR   = 12'hFFF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [9:0]  pixel_x,
    input  logic [9:0]  pixel_y,
    input  logic        video_on,
    input  logic        pause,
    output logic [11:0] RGB,
    output logic        frame_tick
);

    typedef enum logic {
        INC = 1'b0,
        DEC = 1'b1
    } dir_t;

    localparam logic [10:0] SZ     = 11'(BOX_SIZE);
    localparam logic [10:0] VEL    = 11'(BOX_VEL);
    localparam logic [10:0] WALL   = 11'(WALL_W);
    localparam logic [10:0] X_LIM  = 11'(H_MAX - WALL_W);
    localparam logic [10:0] Y_LIM  = 11'(V_MAX - WALL_W);
    localparam logic [10:0] X_HI   = 11'(H_MAX - WALL_W - BOX_SIZE);
    localparam logic [10:0] Y_HI   = 11'(V_MAX - WALL_W - BOX_SIZE);
    localparam logic [10:0] LO_LIM = 11'(WALL_W + BOX_VEL);
    localparam logic [10:0] X_RST  = 11'((H_MAX - BOX_SIZE) / 2);
    localparam logic [10:0] Y_RST  = 11'((V_MAX - BOX_SIZE) / 2);
    localparam logic [10:0] TICK_Y = 11'(V_MAX + 1);

    logic [10:0] x;
    logic [10:0] y;
    logic        tick_cond;
    logic        tick_d;
    logic        step;

    assign x = {1'b0, pixel_x};
    assign y = {1'b0, pixel_y};

    // The sync stage holds each count for several clocks, so edge-detect
    assign tick_cond = (y == TICK_Y) && (x == 11'd0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tick_d     <= 1'b0;
            frame_tick <= 1'b0;
        end else begin
            tick_d     <= tick_cond;
            frame_tick <= tick_cond & ~tick_d;
        end
    end

    assign step = frame_tick & ~pause;

    dir_t        dir_x;
    dir_t        dir_x_nxt;
    dir_t        dir_y;
    dir_t        dir_y_nxt;
    logic [10:0] box_x;
    logic [10:0] box_x_nxt;
    logic [10:0] box_y;
    logic [10:0] box_y_nxt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            box_x <= X_RST;
            box_y <= Y_RST;
            dir_x <= INC;
            dir_y <= INC;
        end else begin
            box_x <= box_x_nxt;
            box_y <= box_y_nxt;
            dir_x <= dir_x_nxt;
            dir_y <= dir_y_nxt;
        end
    end

    always_comb begin
        box_x_nxt = box_x;
        dir_x_nxt = dir_x;
        if (step) begin
            unique case (dir_x)
                INC: begin
                    if (box_x + SZ + VEL >= X_LIM) begin
                        box_x_nxt = X_HI;
                        dir_x_nxt = DEC;
                    end else begin
                        box_x_nxt = box_x + VEL;
                    end
                end
                DEC: begin
                    if (box_x <= LO_LIM) begin
                        box_x_nxt = WALL;
                        dir_x_nxt = INC;
                    end else begin
                        box_x_nxt = box_x - VEL;
                    end
                end
            endcase
        end
    end

    always_comb begin
        box_y_nxt = box_y;
        dir_y_nxt = dir_y;
        if (step) begin
            unique case (dir_y)
                INC: begin
                    if (box_y + SZ + VEL >= Y_LIM) begin
                        box_y_nxt = Y_HI;
                        dir_y_nxt = DEC;
                    end else begin
                        box_y_nxt = box_y + VEL;
                    end
                end
                DEC: begin
                    if (box_y <= LO_LIM) begin
                        box_y_nxt = WALL;
                        dir_y_nxt = INC;
                    end else begin
                        box_y_nxt = box_y - VEL;
                    end
                end
            endcase
        end
    end

    logic        wall_on;
    logic        box_on;
    logic [11:0] rgb_nxt;

    assign wall_on = (x < WALL) || (x >= X_LIM) ||
                     (y < WALL) || (y >= Y_LIM);

    assign box_on = (x >= box_x) && (x < box_x + SZ) &&
                    (y >= box_y) && (y < box_y + SZ);

    always_comb begin
        rgb_nxt = BG_COLOR;
        if (!video_on) begin
            rgb_nxt = 12'h000;
        end else if (box_on) begin
            rgb_nxt = BOX_COLOR;
        end else if (wall_on) begin
            rgb_nxt = WALL_COLOR;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            RGB <= 12'h000;
        end else begin
            RGB <= rgb_nxt;
        end
    end

endmodule

// File: tb/tb_bouncing_box_gen.sv
// Bench for bouncing_box_gen: random pixels and frame ticks checked
// against a clamp-and-reflect model of the box motion.
module tb_bouncing_box_gen;

    localparam int XLO = 8;
    localparam int XHI = 600;
    localparam int YHI = 440;
    localparam int BOX = 32;
    localparam int VEL = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic [9:0]  pixel_x;
    logic [9:0]  pixel_y;
    logic        video_on;
    logic        pause;
    logic [11:0] rgb;
    logic        frame_tick;

    int checks = 0;
    int passed = 0;
    int mx, my, dx, dy;

    always #5 clk = ~clk;

    bouncing_box_gen dut (
        .clk        (clk),
        .reset      (reset),
        .pixel_x    (pixel_x),
        .pixel_y    (pixel_y),
        .video_on   (video_on),
        .pause      (pause),
        .RGB        (rgb),
        .frame_tick (frame_tick)
    );

    task automatic model_reset();
        mx = 304;
        my = 224;
        dx = 1;
        dy = 1;
    endtask

    // Move by the velocity, then clamp to the interior and reflect on contact
    task automatic model_step(input logic held);
        int nx, ny;
        if (!held) begin
            nx = mx + VEL * dx;
            ny = my + VEL * dy;
            if (nx >= XHI) begin mx = XHI; dx = -1; end
            else if (nx <= XLO) begin mx = XLO; dx = 1; end
            else mx = nx;
            if (ny >= YHI) begin my = YHI; dy = -1; end
            else if (ny <= XLO) begin my = XLO; dy = 1; end
            else my = ny;
        end
    endtask

    function automatic logic [11:0] model_rgb(int x, int y, logic v);
        if (!v) return 12'h000;
        if (x >= mx && x < mx + BOX && y >= my && y < my + BOX) return 12'hF00;
        if (x < 8 || x >= 632 || y < 8 || y >= 472) return 12'h00F;
        return 12'hFFF;
    endfunction

    task automatic sample_px(input int x, input int y, input logic v,
                             output logic [11:0] got);
        @(negedge clk);
        pixel_x  = 10'(x);
        pixel_y  = 10'(y);
        video_on = v;
        @(posedge clk);
        #1 got = rgb;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        model_reset();
    endtask

    task automatic issue_tick(input int hold, output int highs, output int first);
        highs = 0;
        first = -1;
        @(negedge clk);
        pixel_x  = 10'd0;
        pixel_y  = 10'd481;
        video_on = 1'b0;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            if (frame_tick === 1'b1) begin
                highs++;
                if (first < 0) first = i;
            end
        end
        @(negedge clk);
        pixel_x = 10'd1;
        @(posedge clk);
        #1;
        if (frame_tick === 1'b1) begin
            highs++;
            if (first < 0) first = hold;
        end
        model_step(pause);
    endtask

    task automatic test_reset();
        logic [11:0] got;
        reset = 1'b1;
        pause = 1'b0;
        pixel_x = 10'd0;
        pixel_y = 10'd481;
        video_on = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (rgb !== 12'h000) $display("FAIL reset_rgb got=%h exp=000", rgb);
        else passed++;
        checks++;
        if (frame_tick !== 1'b0) $display("FAIL reset_tick got=%b exp=0", frame_tick);
        else passed++;
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        sample_px(310, 230, 1'b1, got);
        checks++;
        if (got !== 12'hF00) $display("FAIL first_box got=%h exp=F00", got);
        else passed++;
        #1 reset = 1'b1;
        #1;
        checks++;
        if (rgb !== 12'h000) $display("FAIL async_reset got=%h exp=000", rgb);
        else passed++;
        @(negedge clk);
        reset = 1'b0;
        model_reset();
    endtask

    task automatic test_priority();
        logic [11:0] got, exp;
        int xs[6], ys[6];
        logic vs[6];
        logic [11:0] es[6];
        int x, y;
        logic v;
        xs = '{2, 100, 639, 304, 336, 400};
        ys = '{100, 100, 479, 224, 224, 300};
        vs = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        es = '{12'h00F, 12'hFFF, 12'h00F, 12'hF00, 12'hFFF, 12'h000};
        for (int k = 0; k < 6; k++) begin
            sample_px(xs[k], ys[k], vs[k], got);
            checks++;
            if (got !== es[k])
                $display("FAIL prio(%0d,%0d) got=%h exp=%h", xs[k], ys[k], got, es[k]);
            else passed++;
        end
        for (int k = 0; k < 40; k++) begin
            x = int'($urandom_range(639));
            y = int'($urandom_range(479));
            v = 1'($urandom_range(3) != 0);
            exp = model_rgb(x, y, v);
            sample_px(x, y, v, got);
            checks++;
            if (got !== exp)
                $display("FAIL rand_px(%0d,%0d,%b) got=%h exp=%h", x, y, v, got, exp);
            else passed++;
        end
    endtask

    task automatic test_frame_tick();
        logic [11:0] got;
        int highs, first;
        do_reset();
        issue_tick(4, highs, first);
        checks++;
        if (highs !== 1 || first !== 0)
            $display("FAIL tick_pulse got=%0d@%0d exp=1@0", highs, first);
        else passed++;
        sample_px(306, 226, 1'b1, got);
        checks++;
        if (got !== 12'hF00) $display("FAIL moved_in got=%h exp=F00", got);
        else passed++;
        sample_px(304, 224, 1'b1, got);
        checks++;
        if (got !== 12'hFFF) $display("FAIL moved_out got=%h exp=FFF", got);
        else passed++;
    endtask

    task automatic test_bounce();
        logic [11:0] got, exp;
        int targets[4];
        int px[6], py[6];
        int n, highs, first;
        targets = '{108, 109, 148, 149};
        do_reset();
        n = 0;
        for (int p = 0; p < 4; p++) begin
            while (n < targets[p]) begin
                issue_tick(int'($urandom_range(5, 2)), highs, first);
                n++;
                checks++;
                if (highs !== 1 || first !== 0)
                    $display("FAIL bounce_pulse t%0d got=%0d@%0d exp=1@0", n, highs, first);
                else passed++;
            end
            px = '{mx, mx + 31, mx - 1, mx + 32, mx, mx};
            py = '{my, my + 31, my, my, my - 1, my + 32};
            for (int k = 0; k < 6; k++) begin
                exp = model_rgb(px[k], py[k], 1'b1);
                sample_px(px[k], py[k], 1'b1, got);
                checks++;
                if (got !== exp)
                    $display("FAIL bounce t%0d (%0d,%0d) got=%h exp=%h",
                             n, px[k], py[k], got, exp);
                else passed++;
            end
        end
        sample_px(598, 358, 1'b1, got);
        checks++;
        if (got !== 12'hF00) $display("FAIL t149_corner got=%h exp=F00", got);
        else passed++;
        sample_px(630, 358, 1'b1, got);
        checks++;
        if (got !== 12'hFFF) $display("FAIL t149_right got=%h exp=FFF", got);
        else passed++;
    endtask

    task automatic test_pause();
        logic [11:0] got, exp;
        int px[6], py[6];
        int highs, first;
        pause = 1'b1;
        for (int t = 0; t < 10; t++) begin
            issue_tick(int'($urandom_range(5, 2)), highs, first);
            checks++;
            if (highs !== 1 || first !== 0)
                $display("FAIL pause_pulse got=%0d@%0d exp=1@0", highs, first);
            else passed++;
        end
        for (int r = 0; r < 2; r++) begin
            px = '{mx, mx + 31, mx - 1, mx + 32, mx, mx};
            py = '{my, my + 31, my, my, my - 1, my + 32};
            for (int k = 0; k < 6; k++) begin
                exp = model_rgb(px[k], py[k], 1'b1);
                sample_px(px[k], py[k], 1'b1, got);
                checks++;
                if (got !== exp)
                    $display("FAIL pause r%0d (%0d,%0d) got=%h exp=%h",
                             r, px[k], py[k], got, exp);
                else passed++;
            end
            pause = 1'b0;
            if (r == 0) issue_tick(3, highs, first);
        end
    endtask

    task automatic test_clamp();
        logic [11:0] got, exp;
        int px[4], py[4];
        int highs, first, t;
        logic v;
        t = 0;
        while (t < 600 && mx != XLO) begin
            issue_tick(int'($urandom_range(4, 2)), highs, first);
            t++;
            px = '{mx, mx - 1, mx, int'($urandom_range(639))};
            py = '{my, my, my - 1, int'($urandom_range(479))};
            for (int k = 0; k < 4; k++) begin
                v = (k < 3) ? 1'b1 : 1'($urandom_range(1));
                exp = model_rgb(px[k], py[k], v);
                sample_px(px[k], py[k], v, got);
                checks++;
                if (got !== exp)
                    $display("FAIL clamp t%0d (%0d,%0d) got=%h exp=%h",
                             t, px[k], py[k], got, exp);
                else passed++;
            end
        end
        checks++;
        if (mx != XLO) $display("FAIL clamp_timeout got=%0d exp=%0d", mx, XLO);
        else passed++;
        issue_tick(3, highs, first);
        sample_px(10, my, 1'b1, got);
        checks++;
        if (got !== 12'hF00) $display("FAIL clamp_rebound got=%h exp=F00", got);
        else passed++;
        sample_px(9, my, 1'b1, got);
        checks++;
        if (got !== 12'hFFF) $display("FAIL clamp_left got=%h exp=FFF", got);
        else passed++;
    endtask

    initial begin
        model_reset();
        test_reset();
        test_priority();
        test_frame_tick();
        test_bounce();
        test_pause();
        test_clamp();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
